// File: rtl/niosii_ci_niosii_cpu_debug_jtag_master.sv
// Virtual-JTAG initiator: turns an (IR, DR) command into a tck-paced UIR/CDR/SDR/UDR
// scan toward the Nios II debug slave and returns the captured tdo word.
module niosii_ci_niosii_cpu_debug_jtag_master #(
  parameter int unsigned IR_WIDTH = 2,
  parameter int unsigned DR_WIDTH = 38,
  parameter int unsigned TCK_HALF = 2
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [IR_WIDTH-1:0] cmd_ir_i,
  input  logic [DR_WIDTH-1:0] cmd_dr_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DR_WIDTH-1:0] rsp_dr_o,
  output logic [IR_WIDTH-1:0] rsp_ir_out_o,
  output logic                vji_tck_o,
  output logic                vji_tdi_o,
  input  logic                vji_tdo_i,
  output logic [IR_WIDTH-1:0] vji_ir_in_o,
  input  logic [IR_WIDTH-1:0] vji_ir_out_i,
  output logic                vji_rti_o,
  output logic                vji_uir_o,
  output logic                vji_cdr_o,
  output logic                vji_sdr_o,
  output logic                vji_udr_o
);

  localparam int unsigned DIV_W = 8;
  localparam int unsigned BIT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_UIR  = 3'd1,
    ST_CDR  = 3'd2,
    ST_SDR  = 3'd3,
    ST_UDR  = 3'd4,
    ST_RESP = 3'd5
  } state_e;

  state_e state_q, state_d;

  logic [DIV_W-1:0]    div_q, div_d;
  logic                tck_q, tck_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DR_WIDTH-1:0] tx_q, tx_d;
  logic [DR_WIDTH-1:0] rx_q, rx_d;
  logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
  logic                tdi_q, tdi_d;
  logic                rti_q, rti_d;
  logic                uir_q, uir_d;
  logic                cdr_q, cdr_d;
  logic                sdr_q, sdr_d;
  logic                udr_q, udr_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DR_WIDTH-1:0] rsp_dr_q, rsp_dr_d;
  logic [IR_WIDTH-1:0] rsp_ir_out_q, rsp_ir_out_d;

  logic scan;
  logic div_wrap;
  logic tck_rise;
  logic tck_fall;
  logic accept;
  logic last_bit;

  // tck phase decode: rise = slave sample point, fall = end of a tck period
  always_comb begin
    scan     = (state_q == ST_UIR) || (state_q == ST_CDR) ||
               (state_q == ST_SDR) || (state_q == ST_UDR);
    div_wrap = (div_q == DIV_W'(TCK_HALF - 1));
    tck_rise = scan && div_wrap && !tck_q;
    tck_fall = scan && div_wrap && tck_q;
    accept   = (state_q == ST_IDLE) && cmd_valid_i;
    last_bit = (bit_q == BIT_W'(DR_WIDTH - 1));
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Non-idle states advance only on a tck falling edge
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cmd_valid_i)                 state_d = ST_UIR;
      ST_UIR:  if (tck_fall)                    state_d = ST_CDR;
      ST_CDR:  if (tck_fall)                    state_d = ST_SDR;
      ST_SDR:  if (tck_fall && last_bit)        state_d = ST_UDR;
      ST_UDR:  if (tck_fall)                    state_d = ST_RESP;
      ST_RESP: if (rsp_valid_q && rsp_ready_i)  state_d = ST_IDLE;
      default:                                  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    div_d        = div_q;
    tck_d        = 1'b0;
    bit_d        = bit_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    ir_in_d      = ir_in_q;
    rsp_dr_d     = rsp_dr_q;
    rsp_ir_out_d = rsp_ir_out_q;

    if (scan) begin
      div_d = div_wrap ? '0 : div_q + DIV_W'(1);
      tck_d = div_wrap ? ~tck_q : tck_q;
    end else begin
      div_d = '0;
    end

    if (accept) begin
      tx_d    = cmd_dr_i;
      rx_d    = '0;
      bit_d   = '0;
      ir_in_d = cmd_ir_i;
    end

    if ((state_q == ST_CDR) && tck_rise) begin
      rsp_ir_out_d = vji_ir_out_i;
    end

    // Capture on rising tck, advance tdi on falling tck
    if ((state_q == ST_SDR) && tck_rise) begin
      rx_d = {vji_tdo_i, rx_q[DR_WIDTH-1:1]};
    end
    if ((state_q == ST_SDR) && tck_fall) begin
      tx_d  = tx_q >> 1;
      bit_d = last_bit ? '0 : bit_q + BIT_W'(1);
    end

    if ((state_q == ST_UDR) && tck_fall) begin
      rsp_dr_d = rx_q;
    end

    uir_d       = (state_d == ST_UIR);
    cdr_d       = (state_d == ST_CDR);
    sdr_d       = (state_d == ST_SDR);
    udr_d       = (state_d == ST_UDR);
    rti_d       = (state_d == ST_IDLE) || (state_d == ST_RESP);
    tdi_d       = (state_d == ST_SDR) ? tx_d[0] : 1'b0;
    cmd_ready_d = (state_d == ST_IDLE);
    // Response is offered from the second RESP cycle, once rsp_dr has settled
    rsp_valid_d = (state_q == ST_RESP) && (state_d == ST_RESP);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      div_q        <= '0;
      tck_q        <= 1'b0;
      bit_q        <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      ir_in_q      <= '0;
      tdi_q        <= 1'b0;
      rti_q        <= 1'b1;
      uir_q        <= 1'b0;
      cdr_q        <= 1'b0;
      sdr_q        <= 1'b0;
      udr_q        <= 1'b0;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_dr_q     <= '0;
      rsp_ir_out_q <= '0;
    end else begin
      div_q        <= div_d;
      tck_q        <= tck_d;
      bit_q        <= bit_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      ir_in_q      <= ir_in_d;
      tdi_q        <= tdi_d;
      rti_q        <= rti_d;
      uir_q        <= uir_d;
      cdr_q        <= cdr_d;
      sdr_q        <= sdr_d;
      udr_q        <= udr_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_dr_q     <= rsp_dr_d;
      rsp_ir_out_q <= rsp_ir_out_d;
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_dr_o     = rsp_dr_q;
  assign rsp_ir_out_o = rsp_ir_out_q;
  assign vji_tck_o    = tck_q;
  assign vji_tdi_o    = tdi_q;
  assign vji_ir_in_o  = ir_in_q;
  assign vji_rti_o    = rti_q;
  assign vji_uir_o    = uir_q;
  assign vji_cdr_o    = cdr_q;
  assign vji_sdr_o    = sdr_q;
  assign vji_udr_o    = udr_q;

endmodule

// File: tb/tb_niosii_ci_niosii_cpu_debug_jtag_master.sv
// Scoreboard bench for the virtual-JTAG initiator: one instance at TCK_HALF=2, one at
// TCK_HALF=1, each talking to a behavioural debug-slave model.
`timescale 1ns/1ps
module tb_niosii_ci_niosii_cpu_debug_jtag_master;

  localparam int unsigned IRW = 2;
  localparam int unsigned DRW = 38;

  typedef struct packed {
    logic [DRW-1:0] dr;
    logic [IRW-1:0] ir;
    logic [15:0]    lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic           cmd_valid [2];
  logic           cmd_ready [2];
  logic [IRW-1:0] cmd_ir    [2];
  logic [DRW-1:0] cmd_dr    [2];
  logic           rsp_valid [2];
  logic           rsp_ready [2];
  logic [DRW-1:0] rsp_dr    [2];
  logic [IRW-1:0] rsp_ir    [2];
  logic           tck       [2];
  logic           tdi       [2];
  logic           tdo       [2];
  logic [IRW-1:0] ir_in     [2];
  logic [IRW-1:0] ir_out    [2];
  logic           rti       [2];
  logic           uir       [2];
  logic           cdr       [2];
  logic           sdr       [2];
  logic           udr       [2];

  logic [DRW-1:0] tdo_pat   [2];
  logic [DRW-1:0] tdo_shift [2];
  logic [DRW-1:0] tdi_cap   [2];
  logic [IRW-1:0] slave_ir  [2];
  int cnt_uir [2];
  int cnt_cdr [2];
  int cnt_sdr [2];
  int cnt_udr [2];
  int sidx    [2];
  int tck_edges [2];
  int excl_err  [2];

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  niosii_ci_niosii_cpu_debug_jtag_master #(
    .IR_WIDTH(IRW), .DR_WIDTH(DRW), .TCK_HALF(2)
  ) u_dut (
    .clk_i(clk), .reset_i(rst),
    .cmd_valid_i(cmd_valid[0]), .cmd_ready_o(cmd_ready[0]),
    .cmd_ir_i(cmd_ir[0]), .cmd_dr_i(cmd_dr[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
    .rsp_dr_o(rsp_dr[0]), .rsp_ir_out_o(rsp_ir[0]),
    .vji_tck_o(tck[0]), .vji_tdi_o(tdi[0]), .vji_tdo_i(tdo[0]),
    .vji_ir_in_o(ir_in[0]), .vji_ir_out_i(ir_out[0]), .vji_rti_o(rti[0]),
    .vji_uir_o(uir[0]), .vji_cdr_o(cdr[0]), .vji_sdr_o(sdr[0]), .vji_udr_o(udr[0])
  );

  niosii_ci_niosii_cpu_debug_jtag_master #(
    .IR_WIDTH(IRW), .DR_WIDTH(DRW), .TCK_HALF(1)
  ) u_dut_fast (
    .clk_i(clk), .reset_i(rst),
    .cmd_valid_i(cmd_valid[1]), .cmd_ready_o(cmd_ready[1]),
    .cmd_ir_i(cmd_ir[1]), .cmd_dr_i(cmd_dr[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
    .rsp_dr_o(rsp_dr[1]), .rsp_ir_out_o(rsp_ir[1]),
    .vji_tck_o(tck[1]), .vji_tdi_o(tdi[1]), .vji_tdo_i(tdo[1]),
    .vji_ir_in_o(ir_in[1]), .vji_ir_out_i(ir_out[1]), .vji_rti_o(rti[1]),
    .vji_uir_o(uir[1]), .vji_cdr_o(cdr[1]), .vji_sdr_o(sdr[1]), .vji_udr_o(udr[1])
  );

  // Slave model: presents tdo LSB first, records tdi and per-strobe tck periods
  for (genvar g = 0; g < 2; g++) begin : g_slave
    assign tdo_shift[g] = tdo_pat[g] >> sidx[g];
    assign tdo[g]       = tdo_shift[g][0];
    assign ir_out[g]    = cdr[g] ? slave_ir[g] : '0;

    always @(posedge tck[g]) begin
      if (uir[g]) begin
        cnt_uir[g] = 0;
        cnt_cdr[g] = 0;
        cnt_sdr[g] = 0;
        cnt_udr[g] = 0;
        sidx[g]    = 0;
        tdi_cap[g] = '0;
        cnt_uir[g] = 1;
      end
      if (cdr[g]) cnt_cdr[g] = cnt_cdr[g] + 1;
      if (sdr[g]) begin
        tdi_cap[g] = {tdi[g], tdi_cap[g][DRW-1:1]};
        sidx[g]    = sidx[g] + 1;
        cnt_sdr[g] = cnt_sdr[g] + 1;
      end
      if (udr[g]) cnt_udr[g] = cnt_udr[g] + 1;
    end

    always @(posedge tck[g] or negedge tck[g]) tck_edges[g] = tck_edges[g] + 1;

    always @(negedge clk) begin
      if (!rst && (($countones({uir[g], cdr[g], sdr[g], udr[g]}) > 1) ||
                   (rti[g] == (uir[g] | cdr[g] | sdr[g] | udr[g]))))
        excl_err[g] = excl_err[g] + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_idle(input bit s, input logic [IRW-1:0] exp_ir);
    check_eq($sformatf("idle_tck%0d", s), 64'(tck[s]), 64'(0));
    check_eq($sformatf("idle_rti%0d", s), 64'(rti[s]), 64'(1));
    check_eq($sformatf("idle_ready%0d", s), 64'(cmd_ready[s]), 64'(1));
    check_eq($sformatf("idle_strobes%0d", s), 64'({uir[s], cdr[s], sdr[s], udr[s]}), 64'(0));
    check_eq($sformatf("idle_ir_in%0d", s), 64'(ir_in[s]), 64'(exp_ir));
    check_eq($sformatf("idle_rsp_valid%0d", s), 64'(rsp_valid[s]), 64'(0));
  endtask

  // One full transaction: drive, wait for response, optionally stall, then consume
  task automatic run_txn(input bit s, input logic [IRW-1:0] ir, input logic [DRW-1:0] dr,
                         input logic [DRW-1:0] pat, input logic [IRW-1:0] sir,
                         input int hold, input bit pulse, input int exp_lat);
    exp_t e;
    exp_t got;
    int   lat;
    int   edges0;
    bit   done;
    tdo_pat[s]  = pat;
    slave_ir[s] = sir;
    @(negedge clk);
    check_eq("ready_before_cmd", 64'(cmd_ready[s]), 64'(1));
    cmd_ir[s]    = ir;
    cmd_dr[s]    = dr;
    cmd_valid[s] = 1'b1;
    rsp_ready[s] = 1'b0;
    e.dr  = pat;
    e.ir  = sir;
    e.lat = 16'(exp_lat);
    sb.push_back(e);
    @(posedge clk);
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 400) begin
      @(posedge clk);
      lat = lat + 1;
      @(negedge clk);
      cmd_valid[s] = 1'b0;
      if (rsp_valid[s]) done = 1'b1;
    end
    if (sb.size() == 0) begin
      check_eq("sb_empty", 64'(0), 64'(1));
      return;
    end
    got = sb.pop_front();
    check_eq("latency", 64'(lat), 64'(got.lat));
    check_eq("rsp_dr", 64'(rsp_dr[s]), 64'(got.dr));
    check_eq("rsp_ir_out", 64'(rsp_ir[s]), 64'(got.ir));
    check_eq("tdi_word", 64'(tdi_cap[s]), 64'(dr));
    check_eq("uir_periods", 64'(cnt_uir[s]), 64'(1));
    check_eq("cdr_periods", 64'(cnt_cdr[s]), 64'(1));
    check_eq("sdr_periods", 64'(cnt_sdr[s]), 64'(DRW));
    check_eq("udr_periods", 64'(cnt_udr[s]), 64'(1));
    check_eq("ready_in_resp", 64'(cmd_ready[s]), 64'(0));
    edges0 = tck_edges[s];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      cmd_valid[s] = pulse & ~cmd_valid[s];
    end
    if (hold > 0) begin
      cmd_valid[s] = 1'b0;
      check_eq("hold_valid", 64'(rsp_valid[s]), 64'(1));
      check_eq("hold_ready", 64'(cmd_ready[s]), 64'(0));
      check_eq("hold_tck_edges", 64'(tck_edges[s]), 64'(edges0));
      check_eq("hold_rsp_dr", 64'(rsp_dr[s]), 64'(got.dr));
    end
    rsp_ready[s] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[s] = 1'b0;
    check_idle(s, ir);
  endtask

  initial begin
    bit reached;
    int seen;
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0;
      rsp_ready[i] = 1'b0;
      cmd_ir[i]    = '0;
      cmd_dr[i]    = '0;
      tdo_pat[i]   = '0;
      slave_ir[i]  = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_idle(1'b0, 2'b00);
    check_idle(1'b1, 2'b00);
    check_eq("rst_rsp_dr", 64'(rsp_dr[0]), 64'(0));
    check_eq("rst_rsp_ir", 64'(rsp_ir[0]), 64'(0));

    run_txn(1'b0, 2'b01, 38'h00_0000_0001, 38'h2A_AAAA_AAAA, 2'b10, 0, 1'b0, 165);
    repeat (10) @(negedge clk);
    check_idle(1'b0, 2'b01);
    check_eq("rsp_ir_holds", 64'(rsp_ir[0]), 64'(2'b10));

    run_txn(1'b0, 2'b11, 38'h15_5555_1234, 38'h01_2345_6789, 2'b01, 50, 1'b1, 165);

    run_txn(1'b1, 2'b10, 38'h3F_0F0F_F0F0, 38'h2A_AAAA_AAAA, 2'b11, 0, 1'b0, 83);
    run_txn(1'b1, 2'b01, DRW'({$urandom(), $urandom()}), DRW'({$urandom(), $urandom()}),
            2'b10, 0, 1'b0, 83);
    run_txn(1'b1, 2'b11, '1, '0, 2'b00, 3, 1'b1, 83);

    // Abort a scan mid-SDR with an asynchronous reset
    tdo_pat[0]  = 38'h3F_FFFF_FFFF;
    slave_ir[0] = 2'b11;
    @(negedge clk);
    cmd_ir[0]    = 2'b10;
    cmd_dr[0]    = 38'h2A_5A5A_5A5A;
    cmd_valid[0] = 1'b1;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    reached = 1'b0;
    for (int n = 0; n < 500 && !reached; n++) begin
      @(negedge clk);
      if (sdr[0] && sidx[0] == 17) reached = 1'b1;
    end
    check_eq("reach_bit17", 64'(reached), 64'(1));
    #2 rst = 1'b1;
    #1;
    check_eq("arst_tck", 64'(tck[0]), 64'(0));
    check_eq("arst_strobes", 64'({uir[0], cdr[0], sdr[0], udr[0]}), 64'(0));
    check_eq("arst_rti", 64'(rti[0]), 64'(1));
    check_eq("arst_tdi", 64'(tdi[0]), 64'(0));
    check_eq("arst_ready", 64'(cmd_ready[0]), 64'(1));
    check_eq("arst_ir_in", 64'(ir_in[0]), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (rsp_valid[0]) seen = seen + 1;
    end
    check_eq("no_rsp_after_rst", 64'(seen), 64'(0));
    check_idle(1'b0, 2'b00);

    run_txn(1'b0, 2'b10, 38'h2A_5A5A_5A5A, 38'h15_C3C3_3C3C, 2'b01, 0, 1'b0, 165);

    check_eq("exclusive0", 64'(excl_err[0]), 64'(0));
    check_eq("exclusive1", 64'(excl_err[1]), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
